wb_bus_arbiter: RTL and testbench
=================================

Name: wb_bus_arbiter

Overview:
- Sequential round-robin bus-ownership controller for a shared Wishbone interconnect.
- Decides which of N_MASTER masters owns the shared master->slave datapath. Its outputs gnt_o and sel_o drive the datapath muxes.
- Honours wb_lock_o: a locked master keeps the bus; an unlocked master is pre-empted at transfer boundaries when others wait.
- Contains a watchdog that terminates a stalled transfer with an error pulse.

Parameters:
- N_MASTER, 4, number of masters; index 0 wins on reset ties; must be >= 2.
- TIMEOUT, 255, wait cycles allowed before watchdog termination; must be >= 1.
- IDX_W, $clog2(N_MASTER), width of sel_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- cyc_i  in  N_MASTER  per-master wb_cyc_o.
- stb_i  in  N_MASTER  per-master wb_stb_o.
- lock_i  in  N_MASTER  per-master wb_lock_o.
- ack_i  in  1  ack from the currently selected slave (post slave mux).
- err_i  in  1  err from the selected slave.
- rty_i  in  1  rty from the selected slave.
- gnt_o  out  N_MASTER  one-hot grant, or all zero; registered.
- sel_o  out  IDX_W  binary index of the granted master; registered; holds its last value when idle.
- busy_o  out  1  high while in OWN.
- tout_err_o  out  1  watchdog error; OR-ed into the master err path by the datapath.

Behaviour:
- Reset (async, while rst_i=1): state=IDLE, gnt_o=0, sel_o=0, busy_o=0, tout_err_o=0, cnt_q=0, last_q=N_MASTER-1. This makes master 0 the first winner.
- States: IDLE, OWN. g = sel_o. term = ack_i|err_i|rty_i|tout_err_o.
- Round-robin pick: from candidate set C, choose the first index with cyc_i set, scanning last_q+1, last_q+2, ... modulo N_MASTER.
- IDLE:
  - gnt_o=0.
  - If cyc_i != 0: next cycle state=OWN, gnt_o=onehot(pick over all masters), sel_o and last_q = picked index.
  - Arbitration latency is exactly 1 cycle from cyc_i high to gnt_o high.
- OWN, evaluated each cycle in priority order:
  1. cyc_i[g]=0 (release): next state=IDLE, gnt_o=0, cnt_q=0. This gives one idle turnaround cycle even if other masters are waiting. Release wins over a simultaneous term.
  2. stb_i[g] & term & lock_i[g]=0 & (cyc_i & ~gnt_o)!=0 (pre-emption): stay in OWN; next cycle grant moves to the RR pick over the other masters (g excluded); last_q updated; cnt_q=0.
  3. Otherwise hold the grant.
- Lock: while lock_i[g]=1, no pre-emption occurs. Lock is sampled in the terminating cycle. Lock asserted by a non-granted master has no effect.
- Watchdog:
  - cnt_q clears when stb_i[g]=0, term=1, or the grant changes.
  - Otherwise cnt_q increments, saturating at TIMEOUT.
  - tout_err_o = OWN & stb_i[g] & ~(ack_i|err_i|rty_i) & (cnt_q==TIMEOUT). This is a combinational decode of registered state.
  - tout_err_o therefore fires in the (TIMEOUT+1)th consecutive wait cycle, for exactly 1 cycle. It counts as term, so it can trigger pre-emption.
  - tout_err_o is never asserted in IDLE.
- Slave responses (ack/err/rty) arriving while stb_i[g]=0 or in IDLE are ignored.
- gnt_o is always one-hot or zero. sel_o always matches the gnt_o bit when gnt_o != 0.
- Reset mid-transfer: all outputs drop asynchronously. Arbitration restarts from master 0 after reset is released.

Test Plan:
- Reset then cyc_i=4'b1010 -> next cycle gnt_o=4'b0010, sel_o=1, busy_o=1. Master 1 drops cyc -> gnt_o=0 for 1 cycle. Then gnt_o=4'b1000, sel_o=3.
- Fairness: all 4 masters hold cyc+stb, lock=0, ack_i pulsed each transfer -> grant rotates 0,1,2,3,0 with one transfer each. No idle cycle between owners.
- Lock: master 2 granted with lock_i[2]=1, master 0 requesting, 3 acks -> gnt_o stays 4'b0100. Lock drops before the 4th ack -> gnt_o=4'b0001 the next cycle.
- Watchdog with TIMEOUT=4: granted master holds stb, no ack -> tout_err_o=1 on the 5th wait cycle only, cnt_q returns to 0. With master 3 waiting, the grant moves to 3 the following cycle.
- Simultaneous release+ack while master 1 waits: cyc_i[g]=0 and ack_i=1 in the same cycle -> IDLE for 1 cycle (gnt_o=0), then gnt_o=4'b0010.
- rst_i asserted asynchronously mid-OWN between clock edges -> gnt_o=0, busy_o=0, tout_err_o=0 immediately. After release with cyc_i=4'b1111 -> gnt_o=4'b0001.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone bus-ownership controller with lock support and a stalled-transfer watchdog.
// gnt_o/sel_o are registered and drive the shared master->slave datapath muxes.

module wb_arb_rr_pick #(
    parameter int N_MASTER = 4,
    parameter int IDX_W    = $clog2(N_MASTER)
) (
    input  logic [N_MASTER-1:0] req,
    input  logic [IDX_W-1:0]    last,
    output logic                found,
    output logic [IDX_W-1:0]    idx,
    output logic [N_MASTER-1:0] onehot
);
    int             pos;
    logic [IDX_W-1:0] cand;

    // Scan last+1, last+2, ... wrapping; the first requester wins.
    always_comb begin
        found = 1'b0;
        idx   = last;
        pos   = 0;
        cand  = '0;
        for (int k = 1; k <= N_MASTER; k++) begin
            pos  = (int'(last) + k) % N_MASTER;
            cand = IDX_W'(pos);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

    for (genvar i = 0; i < N_MASTER; i++) begin : g_oh
        assign onehot[i] = found && (idx == IDX_W'(i));
    end
endmodule

module wb_bus_arbiter #(
    parameter int N_MASTER = 4,
    parameter int TIMEOUT  = 255,
    parameter int IDX_W    = $clog2(N_MASTER)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_MASTER-1:0] cyc_i,
    input  logic [N_MASTER-1:0] stb_i,
    input  logic [N_MASTER-1:0] lock_i,
    input  logic                ack_i,
    input  logic                err_i,
    input  logic                rty_i,
    output logic [N_MASTER-1:0] gnt_o,
    output logic [IDX_W-1:0]    sel_o,
    output logic                busy_o,
    output logic                tout_err_o
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t              state_q, state_d;
    logic [N_MASTER-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]    sel_q, sel_d, last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                all_found, oth_found;
    logic [IDX_W-1:0]    all_idx, oth_idx;
    logic [N_MASTER-1:0] all_oh, oth_oh;
    logic                cyc_g, stb_g, lock_g, resp, term;

    // Fresh arbitration from IDLE considers everybody; pre-emption excludes the owner.
    wb_arb_rr_pick #(.N_MASTER(N_MASTER), .IDX_W(IDX_W)) u_pick_all (
        .req(cyc_i), .last(last_q), .found(all_found), .idx(all_idx), .onehot(all_oh)
    );

    wb_arb_rr_pick #(.N_MASTER(N_MASTER), .IDX_W(IDX_W)) u_pick_oth (
        .req(cyc_i & ~gnt_q), .last(last_q), .found(oth_found), .idx(oth_idx), .onehot(oth_oh)
    );

    assign cyc_g  = cyc_i[sel_q];
    assign stb_g  = stb_i[sel_q];
    assign lock_g = lock_i[sel_q];
    assign resp   = ack_i | err_i | rty_i;

    assign tout_err_o = (state_q == OWN) && stb_g && !resp && (cnt_q == CNT_W'(TIMEOUT));
    assign term       = resp | tout_err_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            last_q  <= IDX_W'(N_MASTER - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                cnt_d = '0;
                if (all_found) begin
                    state_d = OWN;
                    gnt_d   = all_oh;
                    sel_d   = all_idx;
                    last_d  = all_idx;
                end
            end
            OWN: begin
                // Release beats a coincident terminator and always costs one idle cycle.
                if (!cyc_g) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end else if (stb_g && term && !lock_g && oth_found) begin
                    gnt_d  = oth_oh;
                    sel_d  = oth_idx;
                    last_d = oth_idx;
                    cnt_d  = '0;
                end else if (!stb_g || term) begin
                    cnt_d = '0;
                end else if (cnt_q != CNT_W'(TIMEOUT)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt_o  = gnt_q;
    assign sel_o  = sel_q;
    assign busy_o = (state_q == OWN);
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed scenarios plus randomized traffic checked against a rule-level reference model.
`timescale 1ns/1ps
module tb_wb_bus_arbiter;
    localparam int N  = 4;
    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] cyc = '0, stb = '0, lock = '0;
    logic         ack = 1'b0, err = 1'b0, rty = 1'b0;
    logic [N-1:0] gnt;
    logic [1:0]   sel;
    logic         busy, tout;

    int checks = 0;
    int failures = 0;

    wb_bus_arbiter #(.N_MASTER(N), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .lock_i(lock),
        .ack_i(ack), .err_i(err), .rty_i(rty),
        .gnt_o(gnt), .sel_o(sel), .busy_o(busy), .tout_err_o(tout)
    );

    always #5 clk = ~clk;

    // Reference model: owner index (or idle), last winner, wait counter.
    bit m_own;
    int m_g, m_last, m_cnt;

    // Smallest requester above last, otherwise smallest requester overall.
    function automatic int rr(input logic [N-1:0] req, input int last);
        int r;
        r = -1;
        for (int i = N - 1; i >= 0; i--) if (req[i] && i > last) r = i;
        if (r < 0) for (int i = N - 1; i >= 0; i--) if (req[i]) r = i;
        return r;
    endfunction

    function automatic bit m_tout();
        return m_own && stb[m_g] && !(ack || err || rty) && (m_cnt == TO);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_own <= 1'b0; m_g <= 0; m_last <= N - 1; m_cnt <= 0;
        end else if (!m_own) begin
            m_cnt <= 0;
            if (cyc != 0) begin
                m_own <= 1'b1; m_g <= rr(cyc, m_last); m_last <= rr(cyc, m_last);
            end
        end else if (!cyc[m_g]) begin
            m_own <= 1'b0; m_cnt <= 0;
        end else if (stb[m_g] && (ack || err || rty || m_tout()) && !lock[m_g]
                     && (cyc & ~(4'b0001 << m_g)) != 0) begin
            m_g    <= rr(cyc & ~(4'b0001 << m_g), m_last);
            m_last <= rr(cyc & ~(4'b0001 << m_g), m_last);
            m_cnt  <= 0;
        end else if (!stb[m_g] || ack || err || rty || m_tout()) begin
            m_cnt <= 0;
        end else begin
            m_cnt <= (m_cnt + 1 > TO) ? TO : m_cnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (sel !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        checks++; if (busy !== 1'b0 || tout !== 1'b0) begin failures++; $display("FAIL reset_busy_tout got=%b%b exp=00", busy, tout); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_handoff();
        cyc = 4'b1010; stb = 4'b1010;
        #1;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL handoff_latency got=%b exp=0000", gnt); end
        tick();
        checks++; if (gnt !== 4'b0010 || sel !== 2'd1 || busy !== 1'b1) begin failures++; $display("FAIL handoff_first got=%b/%0d/%b exp=0010/1/1", gnt, sel, busy); end
        cyc = 4'b1000; stb = 4'b1000;
        tick();
        checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd1) begin failures++; $display("FAIL handoff_idle got=%b/%0d/%b exp=0000/1/0", gnt, sel, busy); end
        tick();
        checks++; if (gnt !== 4'b1000 || sel !== 2'd3) begin failures++; $display("FAIL handoff_second got=%b/%0d exp=1000/3", gnt, sel); end
        cyc = '0; stb = '0;
        tick();
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp;
        cyc = 4'b1111; stb = 4'b1111;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL fair_start got=%b exp=0001", gnt); end
        ack = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp = 4'b0001 << (k % 4);
            checks++; if (gnt !== exp || busy !== 1'b1) begin failures++; $display("FAIL fair_rotate%0d got=%b/%b exp=%b/1", k, gnt, busy, exp); end
        end
        ack = 1'b0; cyc = '0; stb = '0;
        tick();
    endtask

    task automatic test_lock();
        cyc = 4'b0100; stb = 4'b0100; lock = 4'b0100;
        tick();
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL lock_grant got=%b exp=0100", gnt); end
        cyc = 4'b0101; stb = 4'b0101; ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL lock_hold%0d got=%b exp=0100", k, gnt); end
        end
        lock = '0;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL lock_release got=%b exp=0001", gnt); end
        ack = 1'b0; cyc = '0; stb = '0;
        tick();
    endtask

    task automatic test_watchdog();
        cyc = 4'b0010; stb = 4'b0010;
        tick();
        for (int w = 1; w <= 5; w++) begin
            #1;
            checks++; if (tout !== (w == 5)) begin failures++; $display("FAIL wdog_a%0d got=%b exp=%b", w, tout, w == 5); end
            tick();
        end
        cyc = 4'b1010;
        for (int w = 1; w <= 5; w++) begin
            #1;
            checks++; if (tout !== (w == 5) || gnt !== 4'b0010) begin failures++; $display("FAIL wdog_b%0d got=%b/%b exp=%b/0010", w, tout, gnt, w == 5); end
            tick();
        end
        checks++; if (gnt !== 4'b1000 || sel !== 2'd3) begin failures++; $display("FAIL wdog_preempt got=%b/%0d exp=1000/3", gnt, sel); end
        cyc = '0; stb = '0;
        tick();
    endtask

    task automatic test_release_ack();
        cyc = 4'b0011; stb = 4'b0011;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL relack_grant got=%b exp=0001", gnt); end
        cyc = 4'b0010; stb = 4'b0010; ack = 1'b1;
        tick();
        checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL relack_idle got=%b/%b exp=0000/0", gnt, busy); end
        ack = 1'b0;
        tick();
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL relack_next got=%b exp=0010", gnt); end
        cyc = '0; stb = '0;
        tick();
    endtask

    task automatic test_async_reset();
        cyc = 4'b0100; stb = 4'b0100;
        tick();
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL arst_pre got=%b exp=0100", gnt); end
        #2 rst = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || tout !== 1'b0 || sel !== 2'd0) begin failures++; $display("FAIL arst_drop got=%b/%b/%b/%0d exp=0000/0/0/0", gnt, busy, tout, sel); end
        cyc = 4'b1111; stb = 4'b1111;
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++; if (gnt !== 4'b0001 || sel !== 2'd0) begin failures++; $display("FAIL arst_restart got=%b/%0d exp=0001/0", gnt, sel); end
        cyc = '0; stb = '0;
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] exp_gnt;
        bit           quiet;
        for (int c = 0; c < 3000; c++) begin
            quiet = ((c / 150) % 3) == 2;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) cyc[i] = ~cyc[i];
                if ($urandom_range(0, 19) == 0) lock[i] = ~lock[i];
                stb[i] = cyc[i] && ($urandom_range(0, 7) != 0);
            end
            ack = !quiet && ($urandom_range(0, 3) == 0);
            err = !quiet && ($urandom_range(0, 29) == 0);
            rty = !quiet && ($urandom_range(0, 29) == 0);
            #1;
            exp_gnt = m_own ? (4'b0001 << m_g) : 4'b0000;
            checks++;
            if (gnt !== exp_gnt || sel !== 2'(m_g) || busy !== m_own || tout !== m_tout()) begin
                failures++;
                $display("FAIL rand_c%0d got=%b/%0d/%b/%b exp=%b/%0d/%b/%b",
                         c, gnt, sel, busy, tout, exp_gnt, m_g, m_own, m_tout());
            end
            tick();
        end
        cyc = '0; stb = '0; lock = '0; ack = 1'b0; err = 1'b0; rty = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_handoff();
        test_fairness();
        test_lock();
        test_watchdog();
        test_release_ack();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
